// File: rtl/btn_event_pkg.sv
// ============================================================================
// Module      : btn_event_pkg
// Description : Shared channel state type, default timing constants and the
//               hold-counter width helper for btn_event_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_t;

  localparam int c_default_repeat_delay  = 50_000_000;
  localparam int c_default_repeat_period = 10_000_000;
  localparam int c_default_long_press    = 200_000_000;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_event_channel.sv
// ============================================================================
// Module      : btn_event_channel
// Description : One level-to-event channel: press, release and hold/repeat
//               pulses, all registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event_channel
  import btn_event_pkg::*;
#(
  parameter int DELAY  = c_default_repeat_delay,
  parameter int PERIOD = c_default_repeat_period,
  parameter bit REPEAT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int c_cnt_max = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int c_cnt_w   = cnt_width(c_cnt_max);

  localparam logic [c_cnt_w-1:0] c_delay_m1  = c_cnt_w'(DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_period_m1 = c_cnt_w'(PERIOD - 1);

  chan_state_t        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_fired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_fired   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_hold    <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_hold    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_level) begin
            o_press <= 1'b1;
            r_cnt   <= '0;
            r_fired <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!i_level) begin
            o_release <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (!r_fired) begin
            // Without repeat, one hold pulse then the counter stays frozen.
            if (r_cnt == c_delay_m1) begin
              o_hold <= 1'b1;
              r_cnt  <= '0;
              if (REPEAT) r_state <= ST_REPEAT;
              else        r_fired <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (!i_level) begin
            o_release <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_cnt == c_period_m1) begin
            o_hold <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/btn_event_gen.sv
// ============================================================================
// Module      : btn_event_gen
// Description : Four button channels plus one power channel turning debounced
//               levels into press/release/hold event pulses.
//               Macro BTN_AUTOREPEAT_EN enables button auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int REPEAT_DELAY  = c_default_repeat_delay,
  parameter int REPEAT_PERIOD = c_default_repeat_period,
  parameter int LONG_PRESS    = c_default_long_press
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       power,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_repeat,
  output logic       power_press,
  output logic       power_long
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit c_btn_repeat_en = 1'b1;
`else
  localparam bit c_btn_repeat_en = 1'b0;
`endif

  logic w_power_release_unused;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_event_channel #(
      .DELAY  (REPEAT_DELAY),
      .PERIOD (REPEAT_PERIOD),
      .REPEAT (c_btn_repeat_en)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_level   (btn[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_hold    (btn_repeat[g])
    );
  end

  btn_event_channel #(
    .DELAY  (LONG_PRESS),
    .PERIOD (1),
    .REPEAT (1'b0)
  ) u_power (
    .clk       (clk),
    .rst       (rst),
    .i_level   (power),
    .o_press   (power_press),
    .o_release (w_power_release_unused),
    .o_hold    (power_long)
  );

endmodule

`default_nettype wire

// File: tb/tb_btn_event_gen.sv
// ============================================================================
// Module      : tb_btn_event_gen
// Description : Directed and randomized bench for btn_event_gen against a
//               run-length event model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_event_gen;

  localparam int c_delay  = 8;
  localparam int c_period = 3;
  localparam int c_long   = 12;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit c_rep = 1'b1;
`else
  localparam bit c_rep = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       power;
  logic [3:0] btn_press, btn_release, btn_repeat;
  logic       power_press, power_long;

  btn_event_gen #(
    .REPEAT_DELAY  (c_delay),
    .REPEAT_PERIOD (c_period),
    .LONG_PRESS    (c_long)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .power       (power),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .power_press (power_press),
    .power_long  (power_long)
  );

  always #5 clk = ~clk;

  wire [13:0] w_outs = {power_long, power_press, btn_repeat, btn_release, btn_press};

  int checks = 0;
  int errors = 0;

  // Reference: outputs follow from the sampled level and how many consecutive
  // cycles it has been sampled high since the last reset.
  logic [13:0] exp_vec;
  logic [4:0]  m_prev;
  int          m_run [5];
  logic        m_valid = 1'b0;
  logic [4:0]  m_x, m_press, m_rel, m_hold;

  always @(posedge clk) begin
    m_x = {power, btn};
    if (rst) begin
      exp_vec = '0;
      m_prev  = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int i = 0; i < 5; i++) begin
        int d;
        bit r;
        d = (i == 4) ? c_long : c_delay;
        r = (i == 4) ? 1'b0 : c_rep;
        m_run[i]  = m_x[i] ? m_run[i] + 1 : 0;
        m_press[i] = m_x[i] && !m_prev[i];
        m_rel[i]   = !m_x[i] && m_prev[i];
        m_hold[i]  = m_x[i] && ((m_run[i] == d + 1) ||
                     (r && m_run[i] > d + 1 && ((m_run[i] - d - 1) % c_period) == 0));
      end
      m_prev  = m_x;
      exp_vec = {m_hold[4], m_press[4], m_hold[3:0], m_rel[3:0], m_press[3:0]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_valid) chk("model", 32'(w_outs), 32'(exp_vec));
  endtask

  initial begin
    rst = 1'b1; btn = '0; power = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs", 32'(w_outs), 32'd0);
    end

    // Single-cycle press of btn[0]
    btn[0] = 1'b1; tick();
    chk("b0_press", 32'(btn_press), 32'h1);
    chk("b0_norel", 32'(btn_release), 32'h0);
    btn[0] = 1'b0; tick();
    chk("b0_press_off", 32'(btn_press), 32'h0);
    chk("b0_release", 32'(btn_release), 32'h1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("b0_quiet", 32'(w_outs), 32'd0);
    end

    // Hold btn[2]; hold pulses at P+8 and, with repeat, P+11, P+14
    btn[2] = 1'b1; tick();
    chk("b2_press", 32'(btn_press), 32'h4);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("b2_repeat", 32'(btn_repeat[2]),
          32'((k == 8) || (c_rep && (k == 11 || k == 14))));
    end
    btn[2] = 1'b0; tick();
    chk("b2_release", 32'(btn_release), 32'h4);
    repeat (3) tick();

    // Release btn[1] on the edge that would have produced its hold pulse
    btn[1] = 1'b1; tick();
    chk("b1_press", 32'(btn_press), 32'h2);
    repeat (7) tick();
    btn[1] = 1'b0; tick();
    chk("b1_release", 32'(btn_release), 32'h2);
    chk("b1_suppressed", 32'(btn_repeat), 32'h0);
    repeat (3) tick();
    chk("b1_after", 32'(w_outs), 32'd0);

    // Power held 30 cycles
    power = 1'b1; tick();
    chk("pwr_press", 32'(power_press), 32'h1);
    for (int k = 1; k < 30; k++) begin
      tick();
      chk("pwr_press_once", 32'(power_press), 32'h0);
      chk("pwr_long", 32'(power_long), 32'(k == 12));
    end
    power = 1'b0; tick();
    chk("pwr_release_quiet", 32'(w_outs), 32'd0);
    repeat (2) tick();

    // Reset while btn[3] is held well past its first hold pulse
    btn[3] = 1'b1; tick();
    chk("b3_press", 32'(btn_press), 32'h8);
    repeat (14) tick();
    rst = 1'b1; tick();
    chk("rst_outs0", 32'(w_outs), 32'd0);
    tick();
    chk("rst_outs1", 32'(w_outs), 32'd0);
    rst = 1'b0; tick();
    chk("b3_repress", 32'(btn_press), 32'h8);
    chk("b3_norel", 32'(btn_release), 32'h0);
    tick();
    chk("b3_press_once", 32'(btn_press), 32'h0);
    btn[3] = 1'b0; tick();
    repeat (2) tick();

    // Randomized levels with occasional reset
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 15) == 0) power = ~power;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; btn = '0; power = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
